// File: rtl/alu_rr_pkg.sv
// Shared types and tables for the register-register ALU control sequencer.
package alu_rr_pkg;

  // Control steps: fetch T0..T2, decode/execute T3..T6.
  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6
  } state_e;

  typedef enum logic [1:0] {
    OpBinary,
    OpUnary,
    OpMulDiv,
    OpIllegal
  } op_class_e;

  // IR field layout
  localparam int unsigned OpcodeW   = 5;
  localparam int unsigned RegFieldW = 4;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcLsb     = 15;

  // Opcodes
  localparam logic [OpcodeW-1:0] OpcAdd  = 5'b00000;
  localparam logic [OpcodeW-1:0] OpcSub  = 5'b00001;
  localparam logic [OpcodeW-1:0] OpcOr   = 5'b00010;
  localparam logic [OpcodeW-1:0] OpcAnd  = 5'b00011;
  localparam logic [OpcodeW-1:0] OpcShr  = 5'b00100;
  localparam logic [OpcodeW-1:0] OpcShra = 5'b00101;
  localparam logic [OpcodeW-1:0] OpcShl  = 5'b00110;
  localparam logic [OpcodeW-1:0] OpcRor  = 5'b00111;
  localparam logic [OpcodeW-1:0] OpcRol  = 5'b01000;
  localparam logic [OpcodeW-1:0] OpcMul  = 5'b01001;
  localparam logic [OpcodeW-1:0] OpcDiv  = 5'b01010;
  localparam logic [OpcodeW-1:0] OpcNeg  = 5'b01011;
  localparam logic [OpcodeW-1:0] OpcNot  = 5'b01100;

  // ALU control codes understood by the existing datapath ALU
  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluSub  = 5'b00001;
  localparam logic [4:0] AluAnd  = 5'b00010;
  localparam logic [4:0] AluOr   = 5'b00011;
  localparam logic [4:0] AluShr  = 5'b00100;
  localparam logic [4:0] AluShra = 5'b00101;
  localparam logic [4:0] AluShl  = 5'b00110;
  localparam logic [4:0] AluRor  = 5'b00111;
  localparam logic [4:0] AluRol  = 5'b01000;
  localparam logic [4:0] AluMul  = 5'b01001;
  localparam logic [4:0] AluDiv  = 5'b01010;
  localparam logic [4:0] AluNeg  = 5'b01011;
  localparam logic [4:0] AluNot  = 5'b01100;

  typedef struct packed {
    op_class_e  op_class;
    logic [4:0] alu_ctrl;
  } op_info_t;

  // Opcode -> (class, ALU control). Undefined opcodes report OpIllegal.
  function automatic op_info_t lookup_op(logic [OpcodeW-1:0] opcode);
    op_info_t info;
    info.op_class = OpBinary;
    info.alu_ctrl = AluAdd;
    case (opcode)
      OpcAdd:  info.alu_ctrl = AluAdd;
      OpcSub:  info.alu_ctrl = AluSub;
      OpcOr:   info.alu_ctrl = AluOr;
      OpcAnd:  info.alu_ctrl = AluAnd;
      OpcShr:  info.alu_ctrl = AluShr;
      OpcShra: info.alu_ctrl = AluShra;
      OpcShl:  info.alu_ctrl = AluShl;
      OpcRor:  info.alu_ctrl = AluRor;
      OpcRol:  info.alu_ctrl = AluRol;
      OpcMul:  begin info.op_class = OpMulDiv; info.alu_ctrl = AluMul; end
      OpcDiv:  begin info.op_class = OpMulDiv; info.alu_ctrl = AluDiv; end
      OpcNeg:  begin info.op_class = OpUnary;  info.alu_ctrl = AluNeg; end
      OpcNot:  begin info.op_class = OpUnary;  info.alu_ctrl = AluNot; end
      default: info.op_class = OpIllegal;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/alu_rr_decode.sv
// Combinational IR decode: op class, ALU control and one-hot register selects.
module alu_rr_decode
  import alu_rr_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ALU_CTRL_W = 5
) (
  input  logic [31:0]           ir_i,
  output op_class_e             op_class_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic [NUM_REGS-1:0]   ra_oh_o,
  output logic [NUM_REGS-1:0]   rb_oh_o,
  output logic [NUM_REGS-1:0]   rc_oh_o
);

  logic [OpcodeW-1:0]   opcode;
  logic [RegFieldW-1:0] ra, rb, rc;
  logic                 fields_ok;
  op_info_t             info;
  logic                 unused_ir;

  assign opcode    = ir_i[OpcodeLsb +: OpcodeW];
  assign ra        = ir_i[RaLsb +: RegFieldW];
  assign rb        = ir_i[RbLsb +: RegFieldW];
  assign rc        = ir_i[RcLsb +: RegFieldW];
  assign unused_ir = ^ir_i[RcLsb-1:0];

  // Table lookup, folding out-of-range register fields into the illegal class
  always_comb begin
    info       = lookup_op(opcode);
    fields_ok  = (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS);
    op_class_o = fields_ok ? info.op_class : OpIllegal;
    alu_ctrl_o = ALU_CTRL_W'(info.alu_ctrl);
  end

  // One-hot expansion of the register fields
  always_comb begin
    ra_oh_o = '0;
    rb_oh_o = '0;
    rc_oh_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ra_oh_o[i] = (32'(ra) == i);
      rb_oh_o[i] = (32'(rb) == i);
      rc_oh_o[i] = (32'(rc) == i);
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Control-step sequencer for register-register ALU instructions: fetch, decode,
// execute, with a held multi-cycle step and HI/LO writeback for MUL/DIV.
module alu_rr_sequencer
  import alu_rr_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ALU_CTRL_W = 5,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [31:0]           ir,
  input  logic                  mem_ready,
  output logic [NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]   reg_out,
  output logic                  pc_out,
  output logic                  pc_in,
  output logic                  inc_pc,
  output logic                  mar_in,
  output logic                  read,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in,
  output logic                  y_in,
  output logic                  z_in,
  output logic                  zlow_out,
  output logic                  zhigh_out,
  output logic                  hi_in,
  output logic                  lo_in,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);

  localparam int unsigned CntW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  op_class_e             op_class;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl;
  logic [NUM_REGS-1:0]   ra_oh, rb_oh, rc_oh;

  alu_rr_decode #(
    .NUM_REGS  (NUM_REGS),
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_decode (
    .ir_i      (ir),
    .op_class_o(op_class),
    .alu_ctrl_o(dec_alu_ctrl),
    .ra_oh_o   (ra_oh),
    .rb_oh_o   (rb_oh),
    .rc_oh_o   (rc_oh)
  );

  // State and MUL/DIV hold counter
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (mem_ready) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        unique case (op_class)
          OpIllegal: state_d = StIdle;
          OpUnary:   state_d = StT5;
          default: begin
            state_d = StT4;
            // Only MUL/DIV looks at the counter; T4 lasts cnt+1 cycles
            cnt_d   = CntW'(MULDIV_LAT - 1);
          end
        endcase
      end
      StT4: begin
        if (op_class == OpMulDiv && cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StT5;
        end
      end
      StT5:   state_d = (op_class == OpMulDiv) ? StT6 : StIdle;
      StT6:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control decode from step and IR
  always_comb begin
    reg_in    = '0;
    reg_out   = '0;
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    alu_ctrl  = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StT0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      StT1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        // PC reloads only once, on the cycle the fetch completes
        pc_in    = mem_ready;
      end
      StT2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      StT3: begin
        unique case (op_class)
          OpIllegal: illegal = 1'b1;
          OpUnary: begin
            reg_out  = rb_oh;
            alu_ctrl = dec_alu_ctrl;
            z_in     = 1'b1;
          end
          default: begin
            reg_out = rb_oh;
            y_in    = 1'b1;
          end
        endcase
      end
      StT4: begin
        reg_out  = rc_oh;
        alu_ctrl = dec_alu_ctrl;
        z_in     = 1'b1;
      end
      StT5: begin
        zlow_out = 1'b1;
        if (op_class == OpMulDiv) begin
          lo_in = 1'b1;
        end else begin
          reg_in = ra_oh;
          done   = 1'b1;
        end
      end
      StT6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: per-cycle control trace model plus a small
// register-file/ALU datapath driven by the DUT controls.
module tb_alu_rr_sequencer;

  localparam int NumRegs = 16;
  localparam int CtrlW   = 5;
  localparam int Lat     = 4;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [4:0] alu_ctrl;
    logic busy, done, illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t exp;
    logic start;
    logic mem_ready;
  } step_t;

  logic clock = 1'b0;
  logic clear, start, mem_ready;
  logic [31:0] ir;
  logic [NumRegs-1:0] reg_in, reg_out;
  logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
  logic [CtrlW-1:0] alu_ctrl;
  logic busy, done, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  alu_rr_sequencer #(
    .NUM_REGS  (NumRegs),
    .ALU_CTRL_W(CtrlW),
    .MULDIV_LAT(Lat)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .ir       (ir),
    .mem_ready(mem_ready),
    .reg_in   (reg_in),
    .reg_out  (reg_out),
    .pc_out   (pc_out),
    .pc_in    (pc_in),
    .inc_pc   (inc_pc),
    .mar_in   (mar_in),
    .read     (read),
    .mdr_in   (mdr_in),
    .mdr_out  (mdr_out),
    .ir_in    (ir_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .zlow_out (zlow_out),
    .zhigh_out(zhigh_out),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .alu_ctrl (alu_ctrl),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  ctl_t dut_v;
  always_comb begin
    dut_v = '0;
    dut_v.reg_in = reg_in;       dut_v.reg_out = reg_out;
    dut_v.pc_out = pc_out;       dut_v.pc_in = pc_in;
    dut_v.inc_pc = inc_pc;       dut_v.mar_in = mar_in;
    dut_v.read = read;           dut_v.mdr_in = mdr_in;
    dut_v.mdr_out = mdr_out;     dut_v.ir_in = ir_in;
    dut_v.y_in = y_in;           dut_v.z_in = z_in;
    dut_v.zlow_out = zlow_out;   dut_v.zhigh_out = zhigh_out;
    dut_v.hi_in = hi_in;         dut_v.lo_in = lo_in;
    dut_v.alu_ctrl = alu_ctrl;   dut_v.busy = busy;
    dut_v.done = done;           dut_v.illegal = illegal;
  end

  // ---------------- datapath model driven by the DUT controls ----------------
  logic [31:0] reg_m [NumRegs];
  logic [31:0] y_m, lo_m, hi_m, bus;
  logic [63:0] z_m;
  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;

  function automatic logic [63:0] alu(input logic [4:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    case (c)
      5'd0:    return {32'b0, a + b};
      5'd3:    return {32'b0, a | b};
      5'd9:    return {32'b0, a} * {32'b0, b};
      5'd12:   return {32'b0, ~b};
      default: return 64'b0;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    for (int i = 0; i < NumRegs; i++) if (reg_out[i]) bus = reg_m[i];
    if (zlow_out)  bus = z_m[31:0];
    if (zhigh_out) bus = z_m[63:32];
  end

  always @(posedge clock) begin
    if (pre_en) reg_m[pre_idx] <= pre_val;
    if (y_in) y_m <= bus;
    if (z_in) z_m <= alu(alu_ctrl, y_m, bus);
    for (int i = 0; i < NumRegs; i++) if (reg_in[i]) reg_m[i] <= bus;
    if (lo_in) lo_m <= bus;
    if (hi_in) hi_m <= bus;
  end

  // ---------------- expected control trace ----------------
  step_t steps[$];

  // 0 binary, 1 unary, 2 mul/div, 3 illegal
  function automatic void classify(input logic [4:0] op, output int cls,
                                   output logic [4:0] ctl);
    ctl = op;
    if (op <= 5'd8) cls = 0;
    else if (op <= 5'd10) cls = 2;
    else if (op <= 5'd12) cls = 1;
    else cls = 3;
    if (op == 5'd2) ctl = 5'd3;
    if (op == 5'd3) ctl = 5'd2;
  endfunction

  function automatic void push(input ctl_t e, input logic s, input logic mr);
    step_t st;
    st.exp = e; st.start = s; st.mem_ready = mr;
    steps.push_back(st);
  endfunction

  function automatic void build(input logic [31:0] v, input int stall, input bit sb);
    int cls;
    logic [4:0] ctl;
    logic [4:0] op = v[31:27];
    logic [3:0] ra = v[26:23];
    logic [3:0] rb = v[22:19];
    logic [3:0] rc = v[18:15];
    ctl_t e;
    classify(op, cls, ctl);
    steps.delete();
    push('0, 1'b1, 1'b1);
    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    push(e, sb, 1'b1);
    e = '0; e.busy = 1; e.zlow_out = 1; e.read = 1; e.mdr_in = 1;
    for (int i = 0; i < stall; i++) push(e, sb, 1'b0);
    e.pc_in = 1;
    push(e, sb, 1'b1);
    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
    push(e, sb, 1'b1);
    e = '0; e.busy = 1;
    if (cls == 3) e.illegal = 1;
    else if (cls == 1) begin
      e.reg_out = 16'(1) << rb; e.alu_ctrl = ctl; e.z_in = 1;
    end else begin
      e.reg_out = 16'(1) << rb; e.y_in = 1;
    end
    push(e, sb, 1'b1);
    if (cls == 0 || cls == 2) begin
      e = '0; e.busy = 1; e.reg_out = 16'(1) << rc; e.alu_ctrl = ctl; e.z_in = 1;
      for (int i = 0; i < ((cls == 2) ? Lat : 1); i++) push(e, sb, 1'b1);
    end
    if (cls != 3) begin
      e = '0; e.busy = 1; e.zlow_out = 1;
      if (cls == 2) e.lo_in = 1;
      else begin e.reg_in = 16'(1) << ra; e.done = 1; end
      push(e, sb, 1'b1);
      if (cls == 2) begin
        e = '0; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; e.done = 1;
        push(e, sb, 1'b1);
      end
    end
    push('0, 1'b0, 1'b1);
  endfunction

  // ---------------- checks ----------------
  task automatic check_ctl(input string name, input ctl_t act, input ctl_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: controls got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_en = 1'b1;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  // Drives one instruction step by step, comparing every cycle against the trace.
  // Entered and left at posedge+1. abort_at >= 0 pulls clear low in that step.
  task automatic run(input string tag, input logic [31:0] v, input int stall, input bit sb,
                     input int abort_at, output int done_at, output int ill_at);
    build(v, stall, sb);
    ir = v;
    done_at = -1;
    ill_at = -1;
    foreach (steps[k]) begin
      start = steps[k].start;
      mem_ready = steps[k].mem_ready;
      @(negedge clock);
      check_ctl($sformatf("%s_cyc%0d", tag, k), dut_v, steps[k].exp);
      if (dut_v.done && done_at < 0) done_at = k;
      if (dut_v.illegal && ill_at < 0) ill_at = k;
      if (k == abort_at) begin
        start = 1'b0;
        #2 clear = 1'b0;
        #1 check_ctl($sformatf("%s_clear_now", tag), dut_v, '0);
        @(posedge clock); #1;
        check_ctl($sformatf("%s_clear_held", tag), dut_v, '0);
        clear = 1'b1;
        @(posedge clock); #1;
        check_ctl($sformatf("%s_after_clear", tag), dut_v, '0);
        return;
      end
      @(posedge clock); #1;
    end
  endtask

  int d_at, i_at;

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
    for (int i = 0; i < NumRegs; i++) reg_m[i] = '0;
    y_m = '0; z_m = '0; lo_m = '0; hi_m = '0;
    #2 check_ctl("reset_outputs", dut_v, '0);
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;

    // OR R2 <- R5 | R6
    preload(5, 32'h34); preload(6, 32'h45);
    run("or", 32'h112B0000, 0, 1'b0, -1, d_at, i_at);
    check_val("or_done_lat", d_at, 6);
    check_val("or_r2", reg_m[2], 32'h75);

    // ADD R8 <- R9 + R10 with a 3-cycle fetch stall
    preload(9, 32'd100); preload(10, 32'd23);
    run("stall", 32'h044D0000, 3, 1'b0, -1, d_at, i_at);
    check_val("stall_done_lat", d_at, 9);
    check_val("stall_r8", reg_m[8], 32'd123);

    // MUL R3 * R4 -> HI/LO
    preload(3, 32'h10000); preload(4, 32'h10000);
    run("mul", 32'h489A0000, 0, 1'b0, -1, d_at, i_at);
    check_val("mul_done_lat", d_at, 10);
    check_val("mul_lo", lo_m, 32'h0);
    check_val("mul_hi", hi_m, 32'h1);

    // Undefined opcode
    run("illegal", 32'hF8000000, 0, 1'b0, -1, d_at, i_at);
    check_val("illegal_at", i_at, 4);
    check_val("illegal_no_done", d_at, -1);

    // clear in the first T4 cycle of a MUL, then a fresh OR
    run("abort", 32'h489A0000, 0, 1'b0, 5, d_at, i_at);
    check_val("abort_no_done", d_at, -1);
    preload(5, 32'hF0); preload(6, 32'h0F);
    run("or2", 32'h112B0000, 0, 1'b0, -1, d_at, i_at);
    check_val("or2_done_lat", d_at, 6);
    check_val("or2_r2", reg_m[2], 32'hFF);

    // NOT R7 <- R1 with start held high while busy
    preload(1, 32'h000000FF);
    run("not", 32'h63880000, 0, 1'b1, -1, d_at, i_at);
    check_val("not_done_lat", d_at, 5);
    check_val("not_r7", reg_m[7], 32'hFFFFFF00);

    // ADD R0 <- R0 + R0
    preload(0, 32'd21);
    run("same", 32'h00000000, 0, 1'b0, -1, d_at, i_at);
    check_val("same_done_lat", d_at, 6);
    check_val("same_r0", reg_m[0], 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Parametrised control-step sequencer for register-register ALU instructions.
- Replaces hand-coded per-instruction T0..T5 control sequences.
- On `start`, drives fetch (T0–T2) and execute steps into the existing datapath: one-hot register in/out selects, bus enables and ALU control.
- Decodes opcode and Ra/Rb/Rc from the IR. Supports binary ops, unary ops (NEG/NOT) and multi-cycle MUL/DIV with HI/LO writeback.

Parameters:
- NUM_REGS, 16, general registers; width of `reg_in`/`reg_out`; register fields are 4 bits.
- ALU_CTRL_W, 5, ALU control width.
- MULDIV_LAT, 4, cycles `z_in` is held in T4 for MUL/DIV (≥1).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  reset, asynchronous, active-low
- start  in  1  begin one instruction; sampled in IDLE only
- ir  in  32  IR register contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- mem_ready  in  1  memory read data valid (T1)
- reg_in  out  NUM_REGS  one-hot register load
- reg_out  out  NUM_REGS  one-hot register drive
- pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  datapath controls
- alu_ctrl  out  ALU_CTRL_W  ALU operation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the final execute step
- illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
  - State is registered.
  - All outputs are combinational decode of state and `ir`.
  - Every control not listed for a state is 0.
- Reset (`clear`=0, any time, including mid-instruction):
  - State goes to IDLE immediately.
  - All outputs 0; `alu_ctrl`=0; internal latency counter cleared.
- IDLE:
  - `start`=1 → T0; otherwise stay.
  - `start` while `busy` is ignored.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`; `alu_ctrl`=0. → T1.
- T1: `zlow_out`, `pc_in`, `read`, `mdr_in`.
  - Stay while `mem_ready`=0; `pc_in` is asserted only in the exit cycle (`mem_ready`=1).
  - → T2 when `mem_ready`=1.
- T2: `mdr_out`, `ir_in`. → T3.
- T3: decode `ir` using the package table.
  - Undefined opcode: `illegal`=1, no other controls, → IDLE.
  - Binary ops (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV): `reg_out[Rb]`, `y_in`. → T4.
  - Unary ops (NEG, NOT): `reg_out[Rb]`, `alu_ctrl`=op, `z_in`. → T5.
- T4: `reg_out[Rc]`, `alu_ctrl`=op, `z_in`.
  - Non-MUL/DIV: 1 cycle. → T5.
  - MUL/DIV: held MULDIV_LAT cycles via down-counter, then → T5.
- T5: `zlow_out`.
  - Non-MUL/DIV: `reg_in[Ra]`, `done`=1, → IDLE.
  - MUL/DIV: `lo_in`. → T6.
- T6 (MUL/DIV only): `zhigh_out`, `hi_in`, `done`=1. → IDLE.
- Register fields:
  - Index ≥ NUM_REGS → `illegal` in T3, → IDLE.
  - Ra = Rb = Rc is legal.
  - R0 is written like any other register.
- Latencies from the `start` cycle, assuming `mem_ready`=1:
  - `done` 6 cycles later for binary ops.
  - 5 cycles later for unary ops.
  - 6 + MULDIV_LAT cycles later for MUL/DIV.
- `reg_in` and `reg_out` are each never multi-hot.
- `mar_in`/`read` are never asserted outside T0/T1.

Decomposition:
- Package `alu_rr_pkg` holds:
  - State enum.
  - Opcode constants and opcode→`alu_ctrl` table, including OR 5'b00010 → 5'b00011 and ADD 5'b00000 → 5'b00000.
  - Op-class enum: BINARY, UNARY, MULDIV, ILLEGAL.
  - IR field bit positions.
- Sub-module `alu_rr_decode`: combinational; `ir` → op class, `alu_ctrl`, one-hot Ra/Rb/Rc, field-range check.

Test Plan:
- OR: datapath loaded R5=0x34, R6=0x45; `ir`=0x112B0000; `start` pulse →
  - T3 `reg_out`=bit5 with `y_in`.
  - T4 `reg_out`=bit6 with `alu_ctrl`=00011.
  - T5 `reg_in`=bit2 with `done`.
  - R2=0x75.
- Fetch stall: hold `mem_ready`=0 for 3 cycles in T1 →
  - `read` and `mdr_in` stay high 4 cycles.
  - `pc_in` high only in the last of those cycles.
  - `done` 3 cycles late.
- MUL with MULDIV_LAT=4, R3=0x10000, R4=0x10000 →
  - `z_in` high 4 cycles in T4.
  - T5 `lo_in`, T6 `hi_in` with `done`.
  - LO=0, HI=1.
- Undefined opcode 5'b11111 → `illegal` pulse in T3; no `reg_in`/`lo_in`/`hi_in` ever asserted; `busy` low on the next cycle.
- `clear` asserted during T4 → all outputs 0 immediately; IDLE; a new `start` runs a full sequence normally.
- NOT R7←R1 → no `y_in`, no T4; `done` 5 cycles after `start`; `start` pulses while `busy` are ignored.
